serdes_tx_arb: RTL
==================

# serdes_tx_arb

Round-robin packet arbiter that shares the SerDes PISO parallel input among `NUM_REQ` byte-stream requesters. Each requester offers bytes with valid/ready plus an end-of-packet flag. The arbiter locks the winner for a whole packet and forwards it to the PISO `d_in_p`/`valid_i_p`/`ready_o_p` handshake. It sits in the `pclk_i` domain, directly in front of the serializer.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (1..16).
- `DATA_W`, 8: byte width; must equal the PISO parallel width.

Ports:
- `pclk_i`  in  1: parallel clock; the only clock.
- `rst_i`  in  1: asynchronous, active-low reset.
- `req_valid_i`  in  NUM_REQ: per-requester valid.
- `req_data_i`  in  NUM_REQ*DATA_W: per-requester byte; requester k occupies bits [k*DATA_W +: DATA_W].
- `req_last_i`  in  NUM_REQ: per-requester end-of-packet flag, qualified by valid.
- `req_ready_o`  out  NUM_REQ: per-requester ready.
- `d_out_o`  out  DATA_W: byte to the PISO (`d_in_p`).
- `valid_o`  out  1: to PISO `valid_i_p`.
- `ready_i`  in  1: from PISO `ready_o_p`.
- `last_o`  out  1: marks the final byte of the packet.
- `grant_o`  out  NUM_REQ: one-hot current owner; zero when idle.
- `busy_o`  out  1: high in any state other than IDLE.

## Operation
- A transfer occurs on a `pclk_i` rising edge where `valid_o && ready_i`.
- IDLE:
  - `valid_o`=0 and all `req_ready_o`=0.
  - If any `req_valid_i` is set, pick the first valid index at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - Register the one-hot result in `grant_o`.
  - Next state is HDR when `SERDES_ARB_HDR_EN` is defined, otherwise DATA.
- HDR (header build only):
  - `d_out_o` = granted index, zero-extended to DATA_W. `valid_o`=1, `last_o`=0.
  - Requester ready is held at 0.
  - On transfer, go to DATA.
- DATA:
  - `d_out_o`, `valid_o` and `last_o` come combinationally from the granted requester.
  - `req_ready_o[g]` = `ready_i`; all other ready bits are 0.
  - On a transfer with `last_o`=1: clear `grant_o`, set `rr_ptr` = (g+1) mod NUM_REQ, go to IDLE.
- Bubbles: if the owner drops valid mid-packet, `valid_o` drops with it. The grant is held indefinitely; there is no timeout.
- Non-owners never see ready, regardless of their valid.
- A single-byte packet (last=1 on the first byte) completes in one DATA transfer.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `grant_o`=0, `valid_o`=0, `last_o`=0, `req_ready_o`=0, `busy_o`=0, `d_out_o`=0.
- Arbitration latency: one cycle. Valid seen in IDLE gives the grant and the HDR/DATA state on the next edge.
- Minimum gap between packets: one IDLE cycle, even when other requesters are waiting.
- The DATA path is combinational from requester to PISO. There is zero added latency per byte once granted.
- Simultaneous requests: pure round-robin from `rr_ptr`. With all requesters permanently valid, grants rotate 0,1,2,...,NUM_REQ-1,0.
- Reset asserted mid-packet:
  - The packet is dropped immediately; outputs return to reset values asynchronously.
  - No resume after reset is released.
- NUM_REQ=1: the grant is always requester 0 and the pointer stays 0.
- Requirement: ceil(log2(NUM_REQ)) ≤ DATA_W.

## Configuration
- `SERDES_ARB_HDR_EN` defined:
  - Each packet is preceded by one header byte carrying the source index.
  - Cost: one extra transfer per packet.
- Not defined:
  - The HDR state and its logic are absent.
  - IDLE goes straight to DATA; packets pass unmodified.

## Structure
- Package `serdes_pkg` holds:
  - the state enum `arb_state_t` (IDLE, HDR, DATA);
  - the localparam function for the index width, `clog2` of NUM_REQ with a minimum of 1.
- Sub-module `rr_pick`: combinational rotate-priority picker.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: one-hot grant and an any-request flag.
- The top level contains the FSM, the pointer register and the output mux.

## Test plan
- Reset: with `rst_i`=0 and all requesters valid, every output reads 0. Release reset; grant 0001 appears one edge after the first valid.
- Single requester 2 sends a 3-byte packet A1,A2,A3 (last on A3), `ready_i`=1:
  - without HDR, `d_out_o` gives A1,A2,A3 with `last_o` on A3, then `grant_o`=0 and `rr_ptr`=3;
  - with HDR, the sequence is 02,A1,A2,A3.
- Contention: all 4 requesters valid with 1-byte packets and `rr_ptr`=0. Grants come in order 0,1,2,3,0, each separated by one IDLE cycle.
- Backpressure: `ready_i` toggled 1,0,0,1 during a packet. No byte is lost or duplicated, and the owner's ready mirrors `ready_i` exactly.
- Owner drops valid for 3 cycles mid-packet while requester 1 is valid. `grant_o` is unchanged, `valid_o`=0 for those cycles, and requester 1 is never readied.
- `rst_i` pulsed low after byte 2 of a 5-byte packet. Outputs clear at once; after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/serdes_pkg.sv
// serdes_pkg: shared types and helpers for the SerDes transmit arbiter.
//   arb_state_t : arbiter FSM states (IDLE, HDR, DATA)
//   idx_w()     : width of a requester index, clog2(n) with a minimum of 1
package serdes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/serdes_tx_arb_rr_pick.sv
// rr_pick: combinational rotate-priority picker.
// Scans the request vector starting at index ptr, wrapping modulo NUM_REQ,
// and returns the first set request as a one-hot grant.
//   req [NUM_REQ] : request vector
//   ptr [PTR_W]   : index with highest priority (must be < NUM_REQ)
//   gnt [NUM_REQ] : one-hot grant, zero when no request is set
//   any           : at least one request is set
module rr_pick
  import serdes_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               any
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    any   = |req;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // One extra bit holds ptr+i before the modulo wrap.
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serdes_tx_arb.sv
// serdes_tx_arb: round-robin packet arbiter in front of the SerDes PISO.
// Locks the winning requester for a whole packet and forwards its bytes to
// the PISO parallel handshake. Optional build macro SERDES_ARB_HDR_EN
// prepends one header byte carrying the source index to every packet.
//   pclk_i       : parallel clock
//   rst_i        : asynchronous reset, active low
//   req_valid_i  : per-requester valid
//   req_data_i   : per-requester byte, requester k at [k*DATA_W +: DATA_W]
//   req_last_i   : per-requester end-of-packet, qualified by valid
//   req_ready_o  : per-requester ready (only the owner, only in DATA)
//   d_out_o      : byte to PISO d_in_p
//   valid_o      : to PISO valid_i_p
//   ready_i      : from PISO ready_o_p
//   last_o       : final byte of packet
//   grant_o      : one-hot current owner, zero when idle
//   busy_o       : arbiter is not idle
module serdes_tx_arb
  import serdes_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                      pclk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]         d_out_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      last_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o
);

  localparam int unsigned PTR_W = idx_w(NUM_REQ);

  arb_state_t          state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic                pick_any;

  logic [PTR_W-1:0]    gidx;
  logic [DATA_W-1:0]   own_data;
  logic                own_valid;
  logic                own_last;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req (req_valid_i),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  // Owner mux driven by the registered one-hot grant; the loop uses constant
  // slice offsets so no variable part-select is needed.
  always_comb begin
    gidx      = '0;
    own_data  = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        gidx      = PTR_W'(k);
        own_data  = req_data_i[k*DATA_W +: DATA_W];
        own_valid = req_valid_i[k];
        own_last  = req_last_i[k];
      end
    end
  end

  always_ff @(posedge pclk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    d_out_o     = '0;
    valid_o     = 1'b0;
    last_o      = 1'b0;
    req_ready_o = '0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_gnt;
`ifdef SERDES_ARB_HDR_EN
          state_d = HDR;
`else
          state_d = DATA;
`endif
        end
      end

`ifdef SERDES_ARB_HDR_EN
      HDR: begin
        d_out_o = DATA_W'(gidx);
        valid_o = 1'b1;
        if (ready_i) begin
          state_d = DATA;
        end
      end
`endif

      DATA: begin
        d_out_o     = own_data;
        valid_o     = own_valid;
        last_o      = own_last & own_valid;
        req_ready_o = grant_q & {NUM_REQ{ready_i}};
        if (own_valid && own_last && ready_i) begin
          grant_d  = '0;
          rr_ptr_d = (gidx == PTR_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

endmodule
